// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared types and helpers for the layer controller.
//   state_t     - controller FSM states
//   CFG_FIELD_W - width of the configuration layer/neuron/data fields
//   cnt_w()     - counter width for a range of n values (never zero)
package nn_ctrl_pkg;
    localparam int CFG_FIELD_W = 32;
    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, WAIT, DRAIN} state_t;
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/layer_controller_input_buffer.sv
// input_buffer: activation store, one write port and one synchronous read port.
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address, data appears on rdata_o one cycle later
//   rdata_o  - registered read data
module input_buffer #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/layer_controller.sv
// layer_controller: sequences one fully-connected layer of neurons.
//   Buffers an input vector, clears the neurons, streams the vector to them,
//   gathers every neuron result and serialises the results downstream.
//   Configuration writes are decoded into one-hot weight/bias strobes.
//   clk, rst_n               - clock, asynchronous active-low reset
//   in_data_i/valid/ready    - incoming activation stream
//   cfg_*                    - configuration write request (accepted in IDLE)
//   neuron_clear_o           - one-cycle clear to all neurons
//   neuron_in_o/valid_o      - broadcast activation stream
//   weight/bias_write_en_o   - one-hot write strobes, weight/bias_data_o payload
//   neuron_out_i/valid_i     - per-neuron results
//   out_data_o/valid/ready   - serialised layer output, out_last_o on final neuron
//   busy_o                   - controller not idle
module layer_controller
    import nn_ctrl_pkg::*;
#(
    parameter int LAYER_NUMBER = 0,
    parameter int NUM_INPUTS   = 256,
    parameter int NUM_NEURONS  = 32,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             in_data_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic                              cfg_valid_i,
    output logic                              cfg_ready_o,
    input  logic                              cfg_is_bias_i,
    input  logic [CFG_FIELD_W-1:0]            cfg_layer_i,
    input  logic [CFG_FIELD_W-1:0]            cfg_neuron_i,
    input  logic [CFG_FIELD_W-1:0]            cfg_data_i,
    output logic                              neuron_clear_o,
    output logic [DATA_WIDTH-1:0]             neuron_in_o,
    output logic                              neuron_valid_o,
    output logic [NUM_NEURONS-1:0]            weight_write_en_o,
    output logic [NUM_NEURONS-1:0]            bias_write_en_o,
    output logic [CFG_FIELD_W-1:0]            weight_data_o,
    output logic [CFG_FIELD_W-1:0]            bias_data_o,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out_i,
    input  logic [NUM_NEURONS-1:0]            neuron_out_valid_i,
    output logic [DATA_WIDTH-1:0]             out_data_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic                              out_last_o,
    output logic                              busy_o
);
    localparam int IW = cnt_w(NUM_INPUTS);
    localparam int OW = cnt_w(NUM_NEURONS);
    localparam logic [IW-1:0] IN_LAST = IW'(NUM_INPUTS - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(NUM_NEURONS - 1);
    localparam logic [CFG_FIELD_W-1:0] LAYER_ID = CFG_FIELD_W'(LAYER_NUMBER);
    localparam logic [CFG_FIELD_W-1:0] NEURON_LIM = CFG_FIELD_W'(NUM_NEURONS);

    state_t                  state_q, state_d;
    logic [IW-1:0]           in_cnt_q, in_cnt_d, k_cnt_q, k_cnt_d;
    logic [OW-1:0]           o_cnt_q, o_cnt_d;
    logic [NUM_NEURONS-1:0]  mask_q, mask_d, wen_q, wen_d, ben_q, ben_d;
    logic [DATA_WIDTH-1:0]   res_q [NUM_NEURONS];
    logic [DATA_WIDTH-1:0]   res_d [NUM_NEURONS];
    logic [CFG_FIELD_W-1:0]  cfg_data_q, cfg_data_d;

    logic                    in_fire, cfg_fire, out_fire, cfg_hit;
    logic [NUM_NEURONS-1:0]  cfg_sel;
    logic [IW-1:0]           wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign in_ready_o        = state_q == IDLE || state_q == LOAD;
    assign cfg_ready_o       = state_q == IDLE;
    assign busy_o            = state_q != IDLE;
    assign neuron_clear_o    = state_q == CLEAR;
    assign neuron_valid_o    = state_q == STREAM;
    assign out_valid_o       = state_q == DRAIN;
    assign out_last_o        = state_q == DRAIN && o_cnt_q == OUT_LAST;
    assign neuron_in_o       = state_q == STREAM ? rd_data : '0;
    assign out_data_o        = state_q == DRAIN ? res_q[o_cnt_q] : '0;
    assign weight_write_en_o = wen_q;
    assign bias_write_en_o   = ben_q;
    assign weight_data_o     = cfg_data_q;
    assign bias_data_o       = cfg_data_q;

    assign in_fire  = in_valid_i && in_ready_o;
    assign cfg_fire = cfg_valid_i && cfg_ready_o;
    assign out_fire = out_valid_o && out_ready_i;
    assign cfg_hit  = cfg_layer_i == LAYER_ID && cfg_neuron_i < NEURON_LIM;
    assign cfg_sel  = NUM_NEURONS'(1) << cfg_neuron_i[OW-1:0];

    // The first beat always lands in slot 0, so IDLE writes there regardless of in_cnt.
    assign wr_addr = state_q == IDLE ? '0 : in_cnt_q;
    // Prefetch: CLEAR fetches element 0 and each STREAM cycle fetches the next one,
    // so the registered read data lines up with neuron_valid_o without bubbles.
    assign rd_addr = (state_q == STREAM && k_cnt_q != IN_LAST) ? k_cnt_q + 1'b1 : '0;

    input_buffer #(
        .DEPTH (NUM_INPUTS),
        .WIDTH (DATA_WIDTH),
        .AW    (IW)
    ) u_buf (
        .clk     (clk),
        .we_i    (in_fire),
        .waddr_i (wr_addr),
        .wdata_i (in_data_i),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        k_cnt_d    = k_cnt_q;
        o_cnt_d    = o_cnt_q;
        mask_d     = mask_q;
        res_d      = res_q;
        cfg_data_d = cfg_data_q;
        wen_d      = '0;
        ben_d      = '0;
        if (cfg_fire && cfg_hit) begin
            wen_d      = cfg_is_bias_i ? '0 : cfg_sel;
            ben_d      = cfg_is_bias_i ? cfg_sel : '0;
            cfg_data_d = cfg_data_i;
        end
        // Results are only meaningful after the neurons have been cleared.
        if (state_q == STREAM || state_q == WAIT) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                if (neuron_out_valid_i[n]) begin
                    mask_d[n] = 1'b1;
                    res_d[n]  = neuron_out_i[n*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        case (state_q)
            IDLE: if (in_fire) begin
                in_cnt_d = (NUM_INPUTS == 1) ? '0 : IW'(1);
                state_d  = (NUM_INPUTS == 1) ? CLEAR : LOAD;
            end
            LOAD: if (in_fire) begin
                in_cnt_d = in_cnt_q == IN_LAST ? '0 : in_cnt_q + 1'b1;
                state_d  = in_cnt_q == IN_LAST ? CLEAR : LOAD;
            end
            CLEAR: begin
                mask_d  = '0;
                k_cnt_d = '0;
                state_d = STREAM;
            end
            STREAM: begin
                k_cnt_d = k_cnt_q == IN_LAST ? '0 : k_cnt_q + 1'b1;
                state_d = k_cnt_q == IN_LAST ? WAIT : STREAM;
            end
            WAIT: if (&mask_q) state_d = DRAIN;
            DRAIN: if (out_fire) begin
                o_cnt_d = o_cnt_q == OUT_LAST ? '0 : o_cnt_q + 1'b1;
                state_d = o_cnt_q == OUT_LAST ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_cnt_q   <= '0;
            k_cnt_q    <= '0;
            o_cnt_q    <= '0;
            mask_q     <= '0;
            res_q      <= '{default: '0};
            cfg_data_q <= '0;
            wen_q      <= '0;
            ben_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            k_cnt_q    <= k_cnt_d;
            o_cnt_q    <= o_cnt_d;
            mask_q     <= mask_d;
            res_q      <= res_d;
            cfg_data_q <= cfg_data_d;
            wen_q      <= wen_d;
            ben_q      <= ben_d;
        end
    end
endmodule
